// File: rtl/cpu_probe_trace.sv
// Multi-channel trace capture for CPU debug probes: circular pre-trigger history,
// fixed post-trigger window, oldest-first valid/ready readout. Define CPU_PROBE_TRIG_MASK_EN to add trig_mask.
module cpu_probe_trace #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8,
  parameter int POST     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*WIDTH-1:0]    probe_in,
  input  logic                         sample_en,
  input  logic [WIDTH-1:0]             trig_value,
`ifdef CPU_PROBE_TRIG_MASK_EN
  input  logic [WIDTH-1:0]             trig_mask,
`endif
  input  logic                         arm,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [CHANNELS*WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic [1:0]                   state,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = CHANNELS * WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, post_cnt;
  logic [AW-1:0] wr_ptr_next, oldest_ptr;
  logic [AW:0]   count_next;
  logic          trig_hit, write_en, rd_fire;

`ifdef CPU_PROBE_TRIG_MASK_EN
  assign trig_hit = ((probe_in[WIDTH-1:0] & trig_mask) == (trig_value & trig_mask));
`else
  assign trig_hit = (probe_in[WIDTH-1:0] == trig_value);
`endif

  // arm wins over any same-cycle write or read transfer.
  assign write_en    = sample_en && !arm && (state == S_ARMED || state == S_CAPTURE);
  assign wr_ptr_next = wr_ptr + AW'(1);
  assign count_next  = (count == FULL) ? count : count + (AW+1)'(1);
  // Low bits of a saturated count are zero, so a full buffer's oldest entry is wr_ptr_next.
  assign oldest_ptr  = wr_ptr_next - count_next[AW-1:0];

  assign rd_valid = (state == S_DONE) && (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign rd_fire  = rd_valid && rd_ready && !arm;

  // NOTE: storage carries no reset; only pointers and flags qualify its contents.
  always_ff @(posedge clk) begin
    if (write_en) mem[wr_ptr] <= probe_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
    end else if (arm) begin
      state    <= S_ARMED;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      case (state)
        S_ARMED, S_CAPTURE: begin
          if (sample_en) begin
            wr_ptr <= wr_ptr_next;
            count  <= count_next;
            if (count == FULL) overflow <= 1'b1;
            if (state == S_ARMED) begin
              if (trig_hit) begin
                if (POST == 0) begin
                  state  <= S_DONE;
                  rd_ptr <= oldest_ptr;
                end else begin
                  post_cnt <= POST_INIT;
                  state    <= S_CAPTURE;
                end
              end
            end else begin
              post_cnt <= post_cnt - AW'(1);
              if (post_cnt == AW'(1)) begin
                state  <= S_DONE;
                rd_ptr <= oldest_ptr;
              end
            end
          end
        end
        S_DONE: begin
          if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - (AW+1)'(1);
            if (count == (AW+1)'(1)) state <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
